// File: rtl/adder_1b_pkg.sv
// -----------------------------------------------------------------------------
// adder_1b_pkg
// Shared definitions for the adder_1b ripple-carry adder:
//   - ADDER_1B_MAX_WIDTH : widest legal operand width.
//   - fa_res_t           : packed {carry, sum} result of one full-adder cell.
//   - fa_eval()          : single-bit full-adder equation shared by fa_cell.
// -----------------------------------------------------------------------------
package adder_1b_pkg;

  localparam int ADDER_1B_MAX_WIDTH = 32;

  typedef struct packed {
    logic c;
    logic s;
  } fa_res_t;

  // One full-adder bit: s = a^b^ci, co = generate | (propagate & ci).
  function automatic fa_res_t fa_eval(input logic a, input logic b, input logic ci);
    fa_res_t res;
    res.s = a ^ b ^ ci;
    res.c = (a & b) | (ci & (a ^ b));
    return res;
  endfunction

endpackage

// File: rtl/adder_1b_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder; one instance per operand bit of
// adder_1b, chained through ci/co.
// Ports:
//   a, b  in  1  operand bits
//   ci    in  1  carry in
//   s     out 1  sum bit
//   co    out 1  carry out
// -----------------------------------------------------------------------------
module fa_cell
  import adder_1b_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_res_t res_s;

  assign res_s = fa_eval(a, b, ci);
  assign s     = res_s.s;
  assign co    = res_s.c;

endmodule

// File: rtl/adder_1b.sv
// -----------------------------------------------------------------------------
// adder_1b
// Parameterised ripple-carry adder built from fa_cell instances. WIDTH=1 is a
// plain full adder. Provides combinational sum/carry plus a registered copy
// (latency 1) qualified by out_valid.
// Parameters:
//   WIDTH      operand width, 1..ADDER_1B_MAX_WIDTH (default 1)
// Ports:
//   clk        in   1      clock, registers update on posedge
//   rst        in   1      asynchronous active-high reset
//   a, b       in   WIDTH  unsigned operands
//   c_in       in   1      carry into bit 0
//   in_valid   in   1      qualifies a/b/c_in for capture
//   sum        out  WIDTH  combinational (a+b+c_in)[WIDTH-1:0]
//   c_out      out  1      combinational carry out of the MSB
//   sum_q      out  WIDTH  registered sum
//   c_out_q    out  1      registered c_out
//   out_valid  out  1      registered in_valid
// Optional feature, enabled by defining ADDER_1B_OVF_EN:
//   ovf        out  1      signed overflow, carry into MSB ^ carry out of MSB
//   ovf_q      out  1      registered ovf, same capture rule as sum_q
// -----------------------------------------------------------------------------
module adder_1b
  import adder_1b_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_out_q,
  output logic             out_valid
`ifdef ADDER_1B_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  if ((WIDTH < 1) || (WIDTH > ADDER_1B_MAX_WIDTH)) begin : g_width_check
    $error("adder_1b: WIDTH out of range 1..%0d", ADDER_1B_MAX_WIDTH);
  end

  // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the final carry out.
  logic [WIDTH:0] carry_s;

  assign carry_s[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_s[i]),
      .s  (sum[i]),
      .co (carry_s[i+1])
    );
  end

  assign c_out = carry_s[WIDTH];

`ifdef ADDER_1B_OVF_EN
  // For WIDTH=1 carry_s[0] is c_in, giving ovf = c_out ^ c_in.
  assign ovf = carry_s[WIDTH] ^ carry_s[WIDTH-1];
`endif

  logic [WIDTH-1:0] sum_d;
  logic             c_out_d;
  logic             out_valid_d;
`ifdef ADDER_1B_OVF_EN
  logic             ovf_d;
`endif

  // Next-state for the output registers: capture on in_valid, otherwise hold.
  always_comb begin
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    out_valid_d = in_valid;
`ifdef ADDER_1B_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d   = sum;
      c_out_d = c_out;
`ifdef ADDER_1B_OVF_EN
      ovf_d   = ovf;
`endif
    end else begin
      sum_d   = sum_q;
      c_out_d = c_out_q;
`ifdef ADDER_1B_OVF_EN
      ovf_d   = ovf_q;
`endif
    end
  end

  // Output registers; async reset clears them and drops any pending capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= {WIDTH{1'b0}};
      c_out_q   <= 1'b0;
      out_valid <= 1'b0;
`ifdef ADDER_1B_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      sum_q     <= sum_d;
      c_out_q   <= c_out_d;
      out_valid <= out_valid_d;
`ifdef ADDER_1B_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_adder_1b.sv
// -----------------------------------------------------------------------------
// tb_adder_1b
// Self-checking bench for adder_1b at WIDTH = 1, 4, 8 and 16. Stimulus is
// applied just after a falling edge; the expected registered result is queued
// and a monitor compares it one rising edge later whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_adder_1b;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst;

  int vecs = 0;
  int miss = 0;

  logic [0:0]  a1,  b1,  s1,  sq1;
  logic [3:0]  a4,  b4,  s4,  sq4;
  logic [7:0]  a8,  b8,  s8,  sq8;
  logic [15:0] a16, b16, s16, sq16;
  logic c1, v1, co1, coq1, ov1;
  logic c4, v4, co4, coq4, ov4;
  logic c8, v8, co8, coq8, ov8;
  logic c16, v16, co16, coq16, ov16;
`ifdef ADDER_1B_OVF_EN
  logic of1, ofq1, of4, ofq4, of8, ofq8, of16, ofq16;
`endif

  logic [32:0] q1[$], q4[$], q8[$], q16[$];
  logic [32:0] last1 = 33'd0, last4 = 33'd0, last8 = 33'd0, last16 = 33'd0;

  // {c_out, sum} for index {a, b, c_in}, worked out by hand.
  logic [1:0] ft [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  adder_1b #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(c1), .in_valid(v1),
    .sum(s1), .c_out(co1), .sum_q(sq1), .c_out_q(coq1), .out_valid(ov1)
`ifdef ADDER_1B_OVF_EN
    , .ovf(of1), .ovf_q(ofq1)
`endif
  );
  adder_1b #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c_in(c4), .in_valid(v4),
    .sum(s4), .c_out(co4), .sum_q(sq4), .c_out_q(coq4), .out_valid(ov4)
`ifdef ADDER_1B_OVF_EN
    , .ovf(of4), .ovf_q(ofq4)
`endif
  );
  adder_1b #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(c8), .in_valid(v8),
    .sum(s8), .c_out(co8), .sum_q(sq8), .c_out_q(coq8), .out_valid(ov8)
`ifdef ADDER_1B_OVF_EN
    , .ovf(of8), .ovf_q(ofq8)
`endif
  );
  adder_1b #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .c_in(c16), .in_valid(v16),
    .sum(s16), .c_out(co16), .sum_q(sq16), .c_out_q(coq16), .out_valid(ov16)
`ifdef ADDER_1B_OVF_EN
    , .ovf(of16), .ovf_q(ofq16)
`endif
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic spurious(input string nm);
    vecs++;
    miss++;
    $display("FAIL %s: out_valid=1 with nothing expected", nm);
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  // Called just after a falling edge with inputs set: check comb outputs,
  // queue registered expectations, then advance to the next falling edge.
  task automatic step();
    logic [32:0] e1, e4, e8, e16;
    #1;
    e1  = ref_add({31'd0, a1}, {31'd0, b1}, c1);
    e4  = ref_add({28'd0, a4}, {28'd0, b4}, c4);
    e8  = ref_add({24'd0, a8}, {24'd0, b8}, c8);
    e16 = ref_add({16'd0, a16}, {16'd0, b16}, c16);
    chk("comb1",  {31'd0, co1, s1},   e1);
    chk("comb4",  {28'd0, co4, s4},   e4);
    chk("comb8",  {24'd0, co8, s8},   e8);
    chk("comb16", {16'd0, co16, s16}, e16);
    if (v1)  q1.push_back(e1);
    if (v4)  q4.push_back(e4);
    if (v8)  q8.push_back(e8);
    if (v16) q16.push_back(e16);
    @(negedge clk);
  endtask

  task automatic idle_all();
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0; v16 = 1'b0;
  endtask

  // Scoreboard monitor: pop on out_valid, otherwise registers must hold.
  always @(posedge clk) begin
    #1;
    if (ov1) begin
      if (q1.size() == 0) spurious("reg1");
      else begin last1 = q1.pop_front(); chk("reg1", {31'd0, coq1, sq1}, last1); end
    end else chk("hold1", {31'd0, coq1, sq1}, last1);
    if (ov4) begin
      if (q4.size() == 0) spurious("reg4");
      else begin last4 = q4.pop_front(); chk("reg4", {28'd0, coq4, sq4}, last4); end
    end else chk("hold4", {28'd0, coq4, sq4}, last4);
    if (ov8) begin
      if (q8.size() == 0) spurious("reg8");
      else begin last8 = q8.pop_front(); chk("reg8", {24'd0, coq8, sq8}, last8); end
    end else chk("hold8", {24'd0, coq8, sq8}, last8);
    if (ov16) begin
      if (q16.size() == 0) spurious("reg16");
      else begin last16 = q16.pop_front(); chk("reg16", {16'd0, coq16, sq16}, last16); end
    end else chk("hold16", {16'd0, coq16, sq16}, last16);
  end

  initial begin
    logic [31:0] r;
    logic [31:0] rv;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; c16 = 1'b0;
    idle_all();

    // Reset state and combinational behaviour with no clock running.
    #1;
    chk("rst_state8",  {23'd0, ov8, coq8, sq8},     33'd0);
    chk("rst_state16", {15'd0, ov16, coq16, sq16},  33'd0);
    chk("comb_noclk",  {31'd0, co1, s1},            33'd1);
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; c1 = i[0];
      #1;
      chk($sformatf("fa_tt_%0d", i), {31'd0, co1, s1}, {31'd0, ft[i]});
    end
`ifdef ADDER_1B_OVF_EN
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    #1 chk("ovf_7f_01", {32'd0, of8}, 33'd1);
    a8 = 8'hFF; b8 = 8'h01;
    #1 chk("ovf_ff_01", {32'd0, of8}, 33'd0);
`endif

    // Start clock, release reset on a falling edge.
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Directed registered path at WIDTH=8: wrap to zero with carry.
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
    step();
    chk("dir_sum_q",     {24'd0, coq8, sq8}, 33'h100);
    chk("dir_out_valid", {32'd0, ov8},       33'd1);
    v8 = 1'b0; a8 = 8'h12;
    step();
    chk("hold_out_valid", {32'd0, ov8},       33'd0);
    chk("hold_sum_q",     {24'd0, coq8, sq8}, 33'h100);

    // All-ones + all-ones + 1 and zero + zero + 0.
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1; v16 = 1'b1;
    step();
    chk("wrap_ones8", {24'd0, coq8, sq8}, 33'h1FF);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    a16 = 16'h0000; b16 = 16'h0000; c16 = 1'b0;
    step();
    chk("zero16", {16'd0, coq16, sq16}, 33'd0);

    // Async reset between edges after a capture.
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; v8 = 1'b1; v16 = 1'b0;
    step();
    idle_all();
    #2;
    rst = 1'b1;
    q1.delete(); q4.delete(); q8.delete(); q16.delete();
    last1 = 33'd0; last4 = 33'd0; last8 = 33'd0; last16 = 33'd0;
    #1;
    chk("async_rst",      {23'd0, ov8, coq8, sq8}, 33'd0);
    chk("rst_comb_unaff", {24'd0, co8, s8},        33'h046);
    // A capture requested while reset is held must be discarded.
    a8 = 8'h55; v8 = 1'b1;
    @(negedge clk);
    chk("rst_discard", {23'd0, ov8, coq8, sq8}, 33'd0);
    v8 = 1'b0;
    rst = 1'b0;

    // Random vectors on all widths, comb and registered paths.
    for (int n = 0; n < 1000; n++) begin
      r = $urandom; a16 = r[15:0]; b16 = r[31:16];
      r = $urandom; a8 = r[7:0]; b8 = r[15:8]; a4 = r[19:16]; b4 = r[23:20];
      a1 = r[24]; b1 = r[25];
      c1 = r[26]; c4 = r[27]; c8 = r[28]; c16 = r[29];
      rv = $urandom;
      v1 = rv[0] | rv[1]; v4 = rv[2] | rv[3]; v8 = rv[4] | rv[5]; v16 = rv[6] | rv[7];
      step();
    end
    idle_all();
    step();
    step();

    chk("drain1",  33'(q1.size()),  33'd0);
    chk("drain4",  33'(q4.size()),  33'd0);
    chk("drain8",  33'(q8.size()),  33'd0);
    chk("drain16", 33'(q16.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
